shift_add_multiplier: RTL and testbench
=======================================

SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 Parameter: WIDTH, 8, operand width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port: start  input  1  request to begin a multiply; sampled on rising edge.
REQ-005 Port: signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 Port: a  input  WIDTH  multiplier operand; sampled with start.
REQ-007 Port: b  input  WIDTH  multiplicand operand; sampled with start.
REQ-008 Port: product  output  2*WIDTH  registered result of the last completed multiply.
REQ-009 Port: busy  output  1  high while an operation is in progress.
REQ-010 Port: done  output  1  one-cycle pulse marking a valid new product.

Function
REQ-011 The FSM SHALL have states IDLE, RUN and DONE.
REQ-012 start=1 in any state SHALL latch a, b and signed_mode, clear the accumulator and iteration counter, and enter RUN on that edge.
REQ-013 start during RUN SHALL abort the current operation and restart with the new operands; no done pulse for the aborted operation.
REQ-014 RUN SHALL perform one add-shift iteration per cycle, for exactly WIDTH iterations.
REQ-015 Per iteration: if multiplier LSB=1, add multiplicand to the upper accumulator half at WIDTH+1 bits; shift the {carry,accumulator} right by one.
REQ-016 Signed mode: multiplicand sign-extended; carry-in on the shift equals the accumulator sign; the final iteration subtracts the multiplicand instead of adding.
REQ-017 After iteration WIDTH the FSM SHALL enter DONE, load product from the accumulator, and assert done for exactly one cycle.
REQ-018 Latency: start sampled at edge N gives done=1 and a valid product from edge N+WIDTH+1 until edge N+WIDTH+2.
REQ-019 DONE SHALL return to IDLE on the next edge unless start=1, which enters RUN.
REQ-020 busy SHALL be 1 exactly in RUN.
REQ-021 product SHALL hold its value in RUN and IDLE; it changes only on entry to DONE or on reset.
REQ-022 The iteration counter SHALL be $clog2(WIDTH+1) bits and SHALL NOT wrap within an operation.
REQ-023 Results SHALL be exact over the full range, including most-negative times most-negative in signed mode.

Reset
REQ-024 While rst_n=0: state IDLE, product=0, busy=0, done=0, counter=0, accumulator and operand registers=0.
REQ-025 Reset asserted mid-RUN SHALL discard the operation; no done pulse after release.
REQ-026 The first start after rst_n rises SHALL behave per REQ-012.

Configuration
REQ-027 Macro SHIFT_ADD_MULT_SIGNED_EN defined: signed_mode SHALL operate per REQ-016.
REQ-028 Macro SHIFT_ADD_MULT_SIGNED_EN undefined: signed_mode port SHALL remain but be ignored; all operations are unsigned, with no subtract or sign-extension logic.

Structure
REQ-029 Package mult_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the counter-width helper function.
REQ-030 Sub-module mult_step SHALL implement one combinational add/subtract-and-shift iteration (inputs: accumulator, multiplicand, lsb, last, signed), instantiated once.

Verification (WIDTH=8)
REQ-031 Unsigned: a=0xFF, b=0xFF, start 1 cycle -> done 9 cycles after the start edge, product=0xFE01, busy high for 8 cycles.
REQ-032 Signed: a=0x80, b=0x80, signed_mode=1 -> product=0x4000; a=0xFF, b=0x01 -> product=0xFFFF.
REQ-033 Zero: a=0x00, b=0xA5 -> product=0x0000; previous product held throughout RUN.
REQ-034 Restart: start (a=3, b=4), then start (a=5, b=6) at iteration 4 -> single done pulse 9 cycles after the second start, product=0x001E.
REQ-035 Reset mid-RUN: rst_n low at iteration 3 -> product=0, busy=0, no done pulse; the next multiply (a=7, b=9) gives product=0x003F.
REQ-036 Macro off: a=0x80, b=0x80, signed_mode=1 -> product=0x4000; a=0xFF, b=0x02 -> product=0x01FE.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: the FSM state type and the
// iteration-counter width helper.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // The counter must reach WIDTH itself, so it needs room for WIDTH+1 values.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_step.sv
// One combinational add/subtract-and-shift iteration of the multiplier.
// Signed support is compiled in only when SHIFT_ADD_MULT_SIGNED_EN is defined.
module mult_step
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   mcand_i,
    input  logic               lsb_i,
    input  logic               last_i,
    input  logic               signed_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0] upper_ext;
    logic [WIDTH:0] mcand_ext;
    logic [WIDTH:0] sum;

`ifdef SHIFT_ADD_MULT_SIGNED_EN
    // The sign-extended upper half supplies the shift carry-in in signed mode;
    // the multiplier's sign bit carries negative weight, hence the final subtract.
    always_comb begin
        upper_ext = {signed_i & acc_i[2*WIDTH-1], acc_i[2*WIDTH-1:WIDTH]};
        mcand_ext = {signed_i & mcand_i[WIDTH-1], mcand_i};
        if (!lsb_i) begin
            sum = upper_ext;
        end else if (signed_i && last_i) begin
            sum = upper_ext - mcand_ext;
        end else begin
            sum = upper_ext + mcand_ext;
        end
        acc_o = {sum, acc_i[WIDTH-1:1]};
    end
`else
    logic unused_ctrl;
    assign unused_ctrl = last_i ^ signed_i;

    always_comb begin
        upper_ext = {1'b0, acc_i[2*WIDTH-1:WIDTH]};
        mcand_ext = {1'b0, mcand_i};
        sum       = lsb_i ? (upper_ext + mcand_ext) : upper_ext;
        acc_o     = {sum, acc_i[WIDTH-1:1]};
    end
`endif

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential shift-add multiplier: WIDTH iterations per product, restartable.
// Define SHIFT_ADD_MULT_SIGNED_EN to honour signed_mode; otherwise all unsigned.
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done
);

    localparam int              CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e             state_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   mcand_q;
    logic               signed_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] product_q;
    logic               busy_q;
    logic               done_q;
    logic               last_iter;

`ifndef SHIFT_ADD_MULT_SIGNED_EN
    logic unused_signed;
    assign unused_signed = signed_mode;
`endif

    assign last_iter = (cnt_q == LAST_CNT);

    mult_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .acc_i   (acc_q),
        .mcand_i (mcand_q),
        .lsb_i   (acc_q[0]),
        .last_i  (last_iter),
        .signed_i(signed_q),
        .acc_o   (acc_d)
    );

    // Accumulator layout: upper half is the running partial product, lower half
    // holds the multiplier, consumed one bit per shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            signed_q  <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (state_q == DONE) begin
                product_q <= acc_q;
                done_q    <= 1'b1;
            end

            if (start) begin
                state_q  <= RUN;
                acc_q    <= {{WIDTH{1'b0}}, a};
                mcand_q  <= b;
`ifdef SHIFT_ADD_MULT_SIGNED_EN
                signed_q <= signed_mode;
`else
                signed_q <= 1'b0;
`endif
                cnt_q    <= '0;
                busy_q   <= 1'b1;
            end else begin
                case (state_q)
                    RUN: begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (last_iter) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign product = product_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier (WIDTH=8): directed cases plus
// randomized operands checked against plain integer multiplication.
module tb_shift_add_multiplier;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           signed_mode = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic [2*W-1:0] product;
    logic           busy;
    logic           done;

    int total = 0;
    int bad = 0;

    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] held_exp = '0;

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .signed_mode(signed_mode),
        .a          (a),
        .b          (b),
        .product    (product),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, expv);
        end
    endtask

    // Reference: exact integer product of the operands as interpreted.
    function automatic logic [2*W-1:0] ref_mult(input logic [W-1:0] x, input logic [W-1:0] y,
                                                input logic s);
        longint xv;
        longint yv;
        longint pv;
        xv = longint'(x);
        yv = longint'(y);
`ifdef SHIFT_ADD_MULT_SIGNED_EN
        if (s) begin
            xv = longint'($signed(x));
            yv = longint'($signed(y));
        end
`endif
        pv = xv * yv;
        return pv[2*W-1:0];
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done actual=%0h required=no_done", product);
            end else begin
                logic [2*W-1:0] e;
                e = exp_q.pop_front();
                check("product", {48'd0, product}, {48'd0, e});
                held_exp = e;
            end
        end
    end

    // Called at a negedge; returns at the negedge just after the start edge.
    task automatic issue(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic si,
                         input bit track, input logic [2*W-1:0] expv);
        a = ai;
        b = bi;
        signed_mode = si;
        start = 1'b1;
        if (track) exp_q.push_back(expv);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        $display("issue a=%02h b=%02h s=%0d exp=%04h tracked=%0d", ai, bi, si, expv, track);
    endtask

    task automatic wait_done(input string name);
        int  busy_cycles;
        bit  seen;
        busy_cycles = 0;
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (done) begin
                seen = 1'b1;
                check({name, "_latency"}, 64'(k), 64'(W + 1));
                break;
            end
            if (busy) begin
                busy_cycles++;
                check({name, "_hold"}, {48'd0, product}, {48'd0, held_exp});
            end
            @(negedge clk);
        end
        if (!seen) check({name, "_timeout"}, 64'd0, 64'd1);
        check({name, "_busy_cycles"}, 64'(busy_cycles), 64'(W));
        @(negedge clk);
        check({name, "_done_width"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        logic [W-1:0]   ra;
        logic [W-1:0]   rb;
        logic           rs;

        repeat (3) @(negedge clk);
        check("reset_product", {48'd0, product}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(8'hFF, 8'hFF, 1'b0, 1'b1, 16'hFE01);
        wait_done("unsigned_ff");

`ifdef SHIFT_ADD_MULT_SIGNED_EN
        issue(8'h80, 8'h80, 1'b1, 1'b1, 16'h4000);
        wait_done("signed_minmin");
        issue(8'hFF, 8'h01, 1'b1, 1'b1, 16'hFFFF);
        wait_done("signed_neg1");
`else
        issue(8'h80, 8'h80, 1'b1, 1'b1, 16'h4000);
        wait_done("nosign_80");
        issue(8'hFF, 8'h02, 1'b1, 1'b1, 16'h01FE);
        wait_done("nosign_ff02");
`endif

        issue(8'h00, 8'hA5, 1'b0, 1'b1, 16'h0000);
        wait_done("zero");

        // Restart: second start lands mid-run, only its result may appear.
        issue(8'd3, 8'd4, 1'b0, 1'b0, 16'h0000);
        repeat (3) @(negedge clk);
        issue(8'd5, 8'd6, 1'b0, 1'b1, 16'h001E);
        wait_done("restart");

        // Reset mid-run: everything clears and the aborted job never completes.
        issue(8'h12, 8'h34, 1'b0, 1'b0, 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_product", {48'd0, product}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        held_exp = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("midrst_quiet_product", {48'd0, product}, 64'd0);
        issue(8'd7, 8'd9, 1'b0, 1'b1, 16'h003F);
        wait_done("after_reset");

        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            if (n == 0) begin ra = 8'h7F; rb = 8'h80; end
            issue(ra, rb, rs, 1'b1, ref_mult(ra, rb, rs));
            wait_done("random");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
